// File: rtl/pll_ctrl_pkg.sv
// Shared types and constants for the PLL supervisor / dynamic-phase sequencer.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_LOCKED    = 3'd3,
        ST_STEP      = 3'd4,
        ST_GAP       = 3'd5,
        ST_LOAD      = 3'd6,
        ST_FAIL      = 3'd7
    } state_t;

    // Fine phase sub-steps per VCO tap inside the PLL.
    localparam int unsigned PHASE_SUBSTEPS = 8;

    // Encoding of the err qualifier on done.
    localparam logic ERR = 1'b1;
    localparam logic OK  = 1'b0;

endpackage

// File: rtl/pll_lock_filter.sv
// Consecutive-high / consecutive-low lock counters with terminal flags.
module pll_lock_filter #(
    parameter int unsigned LOCK_STABLE = 256,
    parameter int unsigned LOSS_FILT   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic lock_in,
    input  logic clr_high,
    output logic stable_c,
    output logic loss_c
);

    localparam int unsigned HW = $clog2(LOCK_STABLE + 1);
    localparam int unsigned LW = $clog2(LOSS_FILT + 1);

    logic [HW-1:0] high_cnt;
    logic [LW-1:0] low_cnt;

    // Terminal flags include the current sample, so they fire on the Nth cycle.
    assign stable_c = lock_in && (high_cnt == HW'(LOCK_STABLE - 1));
    assign loss_c   = !lock_in && (low_cnt == LW'(LOSS_FILT - 1));

    // Count consecutive high cycles; held at zero when qualification is not active.
    always_ff @(posedge clk) begin
        if (rst || clr_high || !lock_in) begin
            high_cnt <= '0;
        end else if (high_cnt != HW'(LOCK_STABLE - 1)) begin
            high_cnt <= high_cnt + HW'(1);
        end
    end

    // Count consecutive low cycles, saturating at the terminal value.
    always_ff @(posedge clk) begin
        if (rst || lock_in) begin
            low_cnt <= '0;
        end else if (low_cnt != LW'(LOSS_FILT - 1)) begin
            low_cnt <= low_cnt + LW'(1);
        end
    end

endmodule

// File: rtl/pll_dyn_ctrl.sv
// PLL reset/lock supervisor with per-channel dynamic phase-shift sequencing.
module pll_dyn_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter  int unsigned NUM_CH       = 5,
    parameter  int unsigned RST_CYCLES   = 64,
    parameter  int unsigned LOCK_TIMEOUT = 65536,
    parameter  int unsigned LOCK_STABLE  = 256,
    parameter  int unsigned LOSS_FILT    = 4,
    parameter  int unsigned MAX_RETRY    = 3,
    parameter  int unsigned STEP_W       = 8,
    parameter  int unsigned STEP_GAP     = 4,
    parameter  int unsigned PHASE_MOD    = 32,
    localparam int unsigned PW           = $clog2(PHASE_MOD)
) (
    input  logic              clkin1,
    input  logic              pll_rst,
    input  logic              pll_lock_in,
    output logic              pll_rst_out,
    output logic [2:0]        phase_sel,
    output logic              phase_dir,
    output logic              phase_step_n,
    output logic              load_phase,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_ch,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    output logic              done,
    output logic              err,
    output logic              locked,
    output logic              fail,
    output logic [7:0]        loss_cnt,
    output logic [PW-1:0]     phase_pos
);

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > RST_CYCLES)
                                    ? ((LOCK_TIMEOUT > STEP_GAP) ? LOCK_TIMEOUT : STEP_GAP)
                                    : ((RST_CYCLES > STEP_GAP) ? RST_CYCLES : STEP_GAP);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RW      = $clog2(MAX_RETRY + 1);

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [STEP_W-1:0]   rem, rem_d;
    logic [RW-1:0]       retry, retry_d;
    logic [PW-1:0]       acc [NUM_CH];
    logic [PW-1:0]       acc_cur, acc_next;
    logic                cap, acc_clr, acc_step, pos_ld, loss_inc;
    logic                done_d, err_d;
    logic                stable_c, loss_c, accept_c;

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE),
        .LOSS_FILT   (LOSS_FILT)
    ) u_lock_filter (
        .clk      (clkin1),
        .rst      (pll_rst),
        .lock_in  (pll_lock_in),
        .clr_high (!(state == ST_WAIT_LOCK || state == ST_STABLE)),
        .stable_c (stable_c),
        .loss_c   (loss_c)
    );

    // Ready follows live lock so an accept can never coincide with a loss detection.
    assign req_ready = (state == ST_LOCKED) && pll_lock_in;
    assign accept_c  = req_valid && req_ready;

    // Modulo-PHASE_MOD step of the addressed channel accumulator.
    always_comb begin
        acc_cur = acc[phase_sel];
        if (phase_dir) begin
            acc_next = (acc_cur == PW'(PHASE_MOD - 1)) ? '0 : acc_cur + PW'(1);
        end else begin
            acc_next = (acc_cur == '0) ? PW'(PHASE_MOD - 1) : acc_cur - PW'(1);
        end
    end

    // State register.
    always_ff @(posedge clkin1) begin
        if (pll_rst) state <= ST_RST_HOLD;
        else         state <= state_d;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt + CNT_W'(1);
        rem_d    = rem;
        retry_d  = retry;
        cap      = 1'b0;
        acc_clr  = 1'b0;
        acc_step = 1'b0;
        pos_ld   = 1'b0;
        loss_inc = 1'b0;
        done_d   = 1'b0;
        err_d    = OK;
        case (state)
            ST_RST_HOLD: begin
                acc_clr = 1'b1;
                if (cnt == CNT_W'(RST_CYCLES - 1)) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_LOCK: begin
                if (pll_lock_in) begin
                    state_d = ST_STABLE;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    cnt_d = '0;
                    if (retry == RW'(MAX_RETRY - 1)) begin
                        state_d = ST_FAIL;
                    end else begin
                        retry_d = retry + RW'(1);
                        state_d = ST_RST_HOLD;
                    end
                end
            end
            ST_STABLE: begin
                if (!pll_lock_in) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (stable_c) begin
                    state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (loss_c) begin
                    state_d  = ST_RST_HOLD;
                    cnt_d    = '0;
                    retry_d  = '0;
                    loss_inc = 1'b1;
                end else if (accept_c) begin
                    if (32'(req_ch) >= NUM_CH) begin
                        done_d = 1'b1;
                        err_d  = ERR;
                    end else if (req_steps == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cap     = 1'b1;
                        rem_d   = req_steps;
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP, ST_GAP, ST_LOAD: begin
                if (loss_c) begin
                    state_d  = ST_RST_HOLD;
                    cnt_d    = '0;
                    retry_d  = '0;
                    loss_inc = 1'b1;
                    done_d   = 1'b1;
                    err_d    = ERR;
                end else if (state == ST_STEP) begin
                    acc_step = 1'b1;
                    rem_d    = rem - STEP_W'(1);
                    state_d  = ST_GAP;
                    cnt_d    = '0;
                end else if (state == ST_GAP) begin
                    if (cnt == CNT_W'(STEP_GAP - 1)) begin
                        cnt_d   = '0;
                        state_d = (rem != '0) ? ST_STEP : ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOCKED;
                    done_d  = 1'b1;
                    pos_ld  = 1'b1;
                end
            end
            ST_FAIL: begin
                state_d = ST_FAIL;
            end
            default: begin
                state_d = ST_RST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    // Counters and registered outputs, decoded from the next state.
    always_ff @(posedge clkin1) begin
        if (pll_rst) begin
            cnt          <= '0;
            rem          <= '0;
            retry        <= '0;
            pll_rst_out  <= 1'b1;
            phase_step_n <= 1'b1;
            phase_sel    <= '0;
            phase_dir    <= 1'b0;
            load_phase   <= 1'b0;
            done         <= 1'b0;
            err          <= OK;
            locked       <= 1'b0;
            fail         <= 1'b0;
            loss_cnt     <= '0;
            phase_pos    <= '0;
        end else begin
            cnt          <= cnt_d;
            rem          <= rem_d;
            retry        <= retry_d;
            pll_rst_out  <= (state_d == ST_RST_HOLD) || (state_d == ST_FAIL);
            phase_step_n <= (state_d != ST_STEP);
            load_phase   <= (state_d == ST_LOAD);
            done         <= done_d;
            err          <= err_d;
            locked       <= (state_d == ST_LOCKED) || (state_d == ST_STEP)
                         || (state_d == ST_GAP)    || (state_d == ST_LOAD);
            fail         <= (state_d == ST_FAIL);
            if (cap) begin
                phase_sel <= req_ch;
                phase_dir <= req_dir;
            end
            if (pos_ld) phase_pos <= acc_cur;
            if (loss_inc && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
        end
    end

    // Per-channel phase accumulators; cleared whenever the PLL is held in reset.
    always_ff @(posedge clkin1) begin
        if (pll_rst || acc_clr) begin
            for (int unsigned i = 0; i < NUM_CH; i++) acc[i] <= '0;
        end else if (acc_step) begin
            acc[phase_sel] <= acc_next;
        end
    end

endmodule
